bldc_startup_seq: RTL



---
 rtl/bldc_seq_pkg.sv | 18 +
 rtl/bldc_tick_gen.sv | 32 +++
 rtl/bldc_startup_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_seq_pkg.sv
// Shared types and widths for the BLDC start-up sequencer.
package bldc_seq_pkg;

    localparam int STATE_W = 3;
    localparam int VEL_W   = 16;
    localparam int OFF_W   = 8;
    localparam int TRQ_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ALIGN    = 3'd1,
        ST_RAMP     = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOPPING = 3'd4,
        ST_FAULT    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/bldc_tick_gen.sv
// Free-running prescaler: produces a one-clk tick pulse every TICK_DIV clocks.
module bldc_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Count 0..TICK_DIV-1 and raise tick_r for the clock right after the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + 1'b1;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/bldc_startup_seq.sv
// Start-up / shut-down sequencer for a sensored BLDC sine-commutation stage:
// align with a fixed field, step the field open-loop while checking that the
// rotor follows, then track the velocity command with a slew limit.
module bldc_startup_seq
    import bldc_seq_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int ALIGN_TICKS = 500,
    parameter int ALIGN_VEL   = 40,
    parameter int RAMP_STEPS  = 128,
    parameter int MIN_MOVE    = 32,
    parameter int SLEW        = 2,
    parameter int TORQUE_RUN  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      fault_in,
    input  logic signed [VEL_W-1:0]   velocity_cmd,
    input  logic        [VEL_W-1:0]   feedback,
    output logic                      enable,
    output logic                      testmode,
    output logic signed [VEL_W-1:0]   velocity,
    output logic signed [OFF_W-1:0]   offset,
    output logic        [TRQ_W-1:0]   torque,
    output logic        [STATE_W-1:0] state,
    output logic                      running,
    output logic                      fault
);

    localparam int VW1     = VEL_W + 1;
    localparam int CNT_MAX = (ALIGN_TICKS > RAMP_STEPS) ? ALIGN_TICKS : RAMP_STEPS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic        [CNT_W-1:0] ALIGN_LAST    = CNT_W'(ALIGN_TICKS - 1);
    localparam logic        [CNT_W-1:0] RAMP_LAST     = CNT_W'(RAMP_STEPS);
    localparam logic signed [VEL_W-1:0] VEL_ALIGN_POS = VEL_W'(ALIGN_VEL);
    localparam logic signed [VEL_W-1:0] VEL_ALIGN_NEG = VEL_W'(-ALIGN_VEL);
    localparam logic signed [VEL_W-1:0] VEL_ZERO      = {VEL_W{1'b0}};
    localparam logic signed [VEL_W-1:0] VEL_SLEW      = VEL_W'(SLEW);
    localparam logic signed [VW1-1:0]   SLEW_W        = VW1'(SLEW);
    localparam logic        [VW1-1:0]   MIN_MOVE_W    = VW1'(MIN_MOVE);
    localparam logic        [TRQ_W-1:0] TRQ_RUN       = TRQ_W'(TORQUE_RUN);
    localparam logic        [TRQ_W-1:0] TRQ_ZERO      = {TRQ_W{1'b0}};
    localparam logic        [OFF_W-1:0] OFF_ZERO      = {OFF_W{1'b0}};
    localparam logic        [OFF_W-1:0] OFF_INC       = {{(OFF_W-1){1'b0}}, 1'b1};
    localparam logic        [OFF_W-1:0] OFF_DEC       = {OFF_W{1'b1}};

    // One slew-limited step of cur toward tgt; the 17-bit difference keeps
    // full-scale sign changes (e.g. +32767 -> -32768) from overflowing.
    function automatic logic signed [VEL_W-1:0] slew_step(
        input logic signed [VEL_W-1:0] cur,
        input logic signed [VEL_W-1:0] tgt
    );
        logic signed [VW1-1:0] diff;
        diff = {tgt[VEL_W-1], tgt} - {cur[VEL_W-1], cur};
        if (diff > SLEW_W) begin
            slew_step = cur + VEL_SLEW;
        end else if (diff < -SLEW_W) begin
            slew_step = cur - VEL_SLEW;
        end else begin
            slew_step = tgt;
        end
    endfunction

    seq_state_e              state_r, state_nxt_s;
    logic                    dir_r, dir_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [VEL_W-1:0]        fb_ref_r, fb_ref_nxt_s;
    logic signed [VEL_W-1:0] vel_r, vel_nxt_s;
    logic [OFF_W-1:0]        off_r, off_nxt_s;
    logic [TRQ_W-1:0]        trq_r, trq_nxt_s;
    logic                    en_r, en_nxt_s;
    logic                    tm_r, tm_nxt_s;
    logic                    run_r, run_nxt_s;
    logic                    flt_r, flt_nxt_s;

    logic                    tick_s;
    logic                    stop_req_s;
    logic signed [VEL_W-1:0] fb_delta_s;
    logic [VW1-1:0]          fb_mag_s;
    logic                    moved_s;

    bldc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    assign stop_req_s = stop | ~start;
    // Rotor travel since the end of ALIGN, taken modulo 2^16 and made absolute.
    assign fb_delta_s = feedback - fb_ref_r;
    assign fb_mag_s   = fb_delta_s[VEL_W-1] ? ({VW1{1'b0}} - {fb_delta_s[VEL_W-1], fb_delta_s})
                                            : {1'b0, fb_delta_s};
    assign moved_s    = (fb_mag_s >= MIN_MOVE_W);

    // Next state plus event-driven values, then the per-state static outputs.
    always_comb begin
        state_nxt_s  = state_r;
        dir_nxt_s    = dir_r;
        cnt_nxt_s    = cnt_r;
        fb_ref_nxt_s = fb_ref_r;
        vel_nxt_s    = vel_r;
        off_nxt_s    = off_r;
        trq_nxt_s    = trq_r;
        en_nxt_s     = en_r;
        tm_nxt_s     = tm_r;
        run_nxt_s    = run_r;
        flt_nxt_s    = flt_r;

        case (state_r)
            ST_IDLE: begin
                if (fault_in) begin
                    state_nxt_s = ST_FAULT;
                end else if (start && !stop) begin
                    state_nxt_s = ST_ALIGN;
                    dir_nxt_s   = velocity_cmd[VEL_W-1];
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    vel_nxt_s   = velocity_cmd[VEL_W-1] ? VEL_ALIGN_NEG : VEL_ALIGN_POS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (fault_in) begin
                    state_nxt_s = ST_FAULT;
                end else if (stop_req_s) begin
                    state_nxt_s = ST_STOPPING;
                    vel_nxt_s   = VEL_ZERO;
                end else if (tick_s) begin
                    if (cnt_r == ALIGN_LAST) begin
                        state_nxt_s  = ST_RAMP;
                        cnt_nxt_s    = {CNT_W{1'b0}};
                        fb_ref_nxt_s = feedback;
                    end else begin
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_ALIGN;
                end
            end
            ST_RAMP: begin
                if (fault_in) begin
                    state_nxt_s = ST_FAULT;
                end else if (stop_req_s) begin
                    state_nxt_s = ST_STOPPING;
                    vel_nxt_s   = VEL_ZERO;
                end else if (tick_s) begin
                    if (cnt_r == RAMP_LAST) begin
                        // Stall check: the rotor must have followed the stepped field.
                        if (moved_s) begin
                            state_nxt_s = ST_RUN;
                        end else begin
                            state_nxt_s = ST_FAULT;
                        end
                    end else begin
                        off_nxt_s = off_r + (dir_r ? OFF_DEC : OFF_INC);
                        cnt_nxt_s = cnt_r + 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_RAMP;
                end
            end
            ST_RUN: begin
                if (fault_in) begin
                    state_nxt_s = ST_FAULT;
                end else if (stop_req_s) begin
                    state_nxt_s = ST_STOPPING;
                end else if (tick_s) begin
                    vel_nxt_s = slew_step(vel_r, velocity_cmd);
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (fault_in) begin
                    state_nxt_s = ST_FAULT;
                end else if (vel_r == VEL_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s) begin
                    vel_nxt_s = slew_step(vel_r, VEL_ZERO);
                end else begin
                    state_nxt_s = ST_STOPPING;
                end
            end
            ST_FAULT: begin
                if (!fault_in && !start) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        case (state_nxt_s)
            ST_IDLE: begin
                en_nxt_s = 1'b0; tm_nxt_s = 1'b0; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b0;
                vel_nxt_s = VEL_ZERO; off_nxt_s = OFF_ZERO;
            end
            ST_ALIGN: begin
                en_nxt_s = 1'b1; tm_nxt_s = 1'b1; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b0;
                off_nxt_s = OFF_ZERO;
            end
            ST_RAMP: begin
                en_nxt_s = 1'b1; tm_nxt_s = 1'b1; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b0;
            end
            ST_RUN: begin
                en_nxt_s = 1'b1; tm_nxt_s = 1'b0; trq_nxt_s = TRQ_RUN;
                run_nxt_s = 1'b1; flt_nxt_s = 1'b0;
                off_nxt_s = OFF_ZERO;
            end
            ST_STOPPING: begin
                en_nxt_s = 1'b1; tm_nxt_s = 1'b0; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b0;
                off_nxt_s = OFF_ZERO;
            end
            ST_FAULT: begin
                en_nxt_s = 1'b0; tm_nxt_s = 1'b0; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b1;
                vel_nxt_s = VEL_ZERO; off_nxt_s = OFF_ZERO;
            end
            default: begin
                en_nxt_s = 1'b0; tm_nxt_s = 1'b0; trq_nxt_s = TRQ_ZERO;
                run_nxt_s = 1'b0; flt_nxt_s = 1'b0;
                vel_nxt_s = VEL_ZERO; off_nxt_s = OFF_ZERO;
            end
        endcase
    end

    // State, sequencing registers and all stage-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            dir_r    <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            fb_ref_r <= {VEL_W{1'b0}};
            vel_r    <= VEL_ZERO;
            off_r    <= OFF_ZERO;
            trq_r    <= TRQ_ZERO;
            en_r     <= 1'b0;
            tm_r     <= 1'b0;
            run_r    <= 1'b0;
            flt_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            dir_r    <= dir_nxt_s;
            cnt_r    <= cnt_nxt_s;
            fb_ref_r <= fb_ref_nxt_s;
            vel_r    <= vel_nxt_s;
            off_r    <= off_nxt_s;
            trq_r    <= trq_nxt_s;
            en_r     <= en_nxt_s;
            tm_r     <= tm_nxt_s;
            run_r    <= run_nxt_s;
            flt_r    <= flt_nxt_s;
        end
    end

    assign enable   = en_r;
    assign testmode = tm_r;
    assign velocity = vel_r;
    assign offset   = off_r;
    assign torque   = trq_r;
    assign state    = state_r;
    assign running  = run_r;
    assign fault    = flt_r;

endmodule
